// File: rtl/ctrl_phase_seq.sv
// rtl/ctrl_phase_seq.sv - filtered ctrl-driven phase sequencer with direction, enable and idle timeout
//
// Steps a phase index through PHASES states on every committed edge of a
// glitch-filtered control input. Stepping is forward or reverse. It can be
// frozen with en. An optional idle timeout returns a nonzero phase to 0.
//
// Ports:
//   clk    in       rising-edge clock
//   reset  in       asynchronous active-high reset
//   ctrl   in       raw control level, synchronous to clk
//   en     in       1 = sequencing enabled, 0 = Y frozen (filter keeps running)
//   dir    in       0 = step forward, 1 = step reverse (sampled at the commit edge)
//   Y      out [YW] current phase index, registered
//   ctrl_f out      filtered ctrl level, registered
//   adv    out      one-cycle pulse on the edge Y steps due to ctrl
//   tout   out      one-cycle pulse on the edge Y is forced to 0 by the timeout
module ctrl_phase_seq #(
    parameter int PHASES  = 4,
    parameter int YW      = 2,
    parameter int FILTER  = 1,
    parameter int TIMEOUT = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ctrl,
    input  logic          en,
    input  logic          dir,
    output logic [YW-1:0] Y,
    output logic          ctrl_f,
    output logic          adv,
    output logic          tout
);

    localparam int FW = $clog2(FILTER) + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [FW-1:0] F_LAST  = FW'(FILTER - 1);
    localparam logic [TW-1:0] T_LAST  = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [YW-1:0] Y_LAST  = YW'(PHASES - 1);
    // One bit wider than Y so that PHASES itself is representable.
    localparam logic [YW:0]   Y_LIMIT = (YW + 1)'(PHASES);

    logic [YW-1:0] r_y;
    logic          r_ctrl_f;
    logic          r_adv;
    logic          r_tout;
    logic [FW-1:0] r_fcnt;
    logic [TW-1:0] r_timer;

    logic [YW-1:0] w_y_nxt;
    logic          w_ctrl_f_nxt;
    logic          w_adv_nxt;
    logic          w_tout_nxt;
    logic [FW-1:0] w_fcnt_nxt;
    logic [TW-1:0] w_timer_nxt;

    logic          w_diff;
    logic          w_commit;
    logic          w_step;
    logic          w_illegal;
    logic          w_expire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_y      <= '0;
            r_ctrl_f <= 1'b0;
            r_adv    <= 1'b0;
            r_tout   <= 1'b0;
            r_fcnt   <= '0;
            r_timer  <= '0;
        end else begin
            r_y      <= w_y_nxt;
            r_ctrl_f <= w_ctrl_f_nxt;
            r_adv    <= w_adv_nxt;
            r_tout   <= w_tout_nxt;
            r_fcnt   <= w_fcnt_nxt;
            r_timer  <= w_timer_nxt;
        end
    end

    always_comb begin
        w_diff    = (ctrl != r_ctrl_f);
        w_commit  = w_diff && (r_fcnt == F_LAST);
        w_step    = w_commit && en;
        w_illegal = ({1'b0, r_y} >= Y_LIMIT);
        // A commit on the expiry edge wins, so expiry is masked by w_step.
        w_expire  = (TIMEOUT > 0) && en && (r_y != '0) && !w_step && (r_timer == T_LAST);
    end

    // Glitch filter: ctrl must disagree with ctrl_f for FILTER consecutive
    // edges; any agreeing edge restarts the count.
    always_comb begin
        w_ctrl_f_nxt = r_ctrl_f;
        w_fcnt_nxt   = r_fcnt;
        if (!w_diff) begin
            w_fcnt_nxt = '0;
        end else if (w_commit) begin
            w_ctrl_f_nxt = ctrl;
            w_fcnt_nxt   = '0;
        end else begin
            w_fcnt_nxt = r_fcnt + FW'(1);
        end
    end

    // Phase update. Illegal-code recovery is silent: no adv or tout.
    always_comb begin
        w_y_nxt    = r_y;
        w_adv_nxt  = 1'b0;
        w_tout_nxt = 1'b0;
        if (w_illegal) begin
            w_y_nxt = '0;
        end else if (w_step) begin
            w_adv_nxt = 1'b1;
            if (!dir) begin
                w_y_nxt = (r_y == Y_LAST) ? '0 : r_y + YW'(1);
            end else begin
                w_y_nxt = (r_y == '0) ? Y_LAST : r_y - YW'(1);
            end
        end else if (w_expire) begin
            w_y_nxt    = '0;
            w_tout_nxt = 1'b1;
        end
    end

    // Idle timer only counts while enabled, parked in a nonzero phase and idle.
    always_comb begin
        if ((TIMEOUT == 0) || !en || (r_y == '0) || w_step || w_expire || w_illegal) begin
            w_timer_nxt = '0;
        end else begin
            w_timer_nxt = r_timer + TW'(1);
        end
    end

    assign Y      = r_y;
    assign ctrl_f = r_ctrl_f;
    assign adv    = r_adv;
    assign tout   = r_tout;

endmodule

// File: tb/tb_ctrl_phase_seq.sv
// tb/tb_ctrl_phase_seq.sv - scoreboard bench for ctrl_phase_seq across four parameter sets
module tb_ctrl_phase_seq;

    logic clk = 1'b0;
    logic reset;
    logic ctrl;
    logic en;
    logic dir;

    logic [1:0] y_def, y_f3, y_to;
    logic [2:0] y_r5;
    logic cf_def, adv_def, tout_def;
    logic cf_f3, adv_f3, tout_f3;
    logic cf_r5, adv_r5, tout_r5;
    logic cf_to, adv_to, tout_to;

    int vecs = 0;
    int errs = 0;

    typedef struct packed {
        logic [2:0] y;
        logic       cf;
        logic       adv;
        logic       tout;
    } exp_t;

    typedef struct {
        logic c;
        logic e;
        logic d;
        exp_t x;
    } row_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    ctrl_phase_seq u_def (
        .clk(clk), .reset(reset), .ctrl(ctrl), .en(en), .dir(dir),
        .Y(y_def), .ctrl_f(cf_def), .adv(adv_def), .tout(tout_def)
    );

    ctrl_phase_seq #(.FILTER(3)) u_f3 (
        .clk(clk), .reset(reset), .ctrl(ctrl), .en(en), .dir(dir),
        .Y(y_f3), .ctrl_f(cf_f3), .adv(adv_f3), .tout(tout_f3)
    );

    ctrl_phase_seq #(.PHASES(5), .YW(3)) u_r5 (
        .clk(clk), .reset(reset), .ctrl(ctrl), .en(en), .dir(dir),
        .Y(y_r5), .ctrl_f(cf_r5), .adv(adv_r5), .tout(tout_r5)
    );

    ctrl_phase_seq #(.TIMEOUT(8)) u_to (
        .clk(clk), .reset(reset), .ctrl(ctrl), .en(en), .dir(dir),
        .Y(y_to), .ctrl_f(cf_to), .adv(adv_to), .tout(tout_to)
    );

    function automatic row_t mk(input logic c, input logic e, input logic d,
                                input int y, input logic cf, input logic adv, input logic tout);
        row_t r;
        r.c = c;
        r.e = e;
        r.d = d;
        r.x.y = 3'(y);
        r.x.cf = cf;
        r.x.adv = adv;
        r.x.tout = tout;
        return r;
    endfunction

    function automatic exp_t obs_def();
        return {1'b0, y_def, cf_def, adv_def, tout_def};
    endfunction
    function automatic exp_t obs_f3();
        return {1'b0, y_f3, cf_f3, adv_f3, tout_f3};
    endfunction
    function automatic exp_t obs_r5();
        return {y_r5, cf_r5, adv_r5, tout_r5};
    endfunction
    function automatic exp_t obs_to();
        return {1'b0, y_to, cf_to, adv_to, tout_to};
    endfunction

    // Drive one row, queue its expectation, and step to just after the edge.
    task automatic apply(input row_t r);
        ctrl = r.c;
        en   = r.e;
        dir  = r.d;
        sb.push_back(r.x);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ctrl  = 1'b0;
        en    = 1'b1;
        dir   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e, o;
        reset = 1'b1;
        ctrl  = 1'b0;
        en    = 1'b1;
        dir   = 1'b0;
        #2;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('0);
            e = sb.pop_front();
            case (k)
                0: o = obs_def();
                1: o = obs_f3();
                2: o = obs_r5();
                default: o = obs_to();
            endcase
            vecs++;
            if (o !== e) begin
                errs++;
                $display("FAIL reset[%0d] got y=%0d cf=%b adv=%b tout=%b want all zero",
                         k, o.y, o.cf, o.adv, o.tout);
            end
        end
    endtask

    task automatic test_basic_steps();
        row_t t[$];
        exp_t e, o;
        do_reset();
        t.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        for (int lv = 1; lv <= 4; lv++) begin
            t.push_back(mk(lv[0], 1, 0, lv % 4, lv[0], 1, 0));
            t.push_back(mk(lv[0], 1, 0, lv % 4, lv[0], 0, 0));
            t.push_back(mk(lv[0], 1, 0, lv % 4, lv[0], 0, 0));
        end
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            o = obs_def();
            vecs++;
            if (o !== e) begin
                errs++;
                $display("FAIL basic[%0d] got y=%0d cf=%b adv=%b tout=%b want y=%0d cf=%b adv=%b tout=%b",
                         i, o.y, o.cf, o.adv, o.tout, e.y, e.cf, e.adv, e.tout);
            end
        end
    endtask

    task automatic test_filter();
        row_t t[$];
        exp_t e, o;
        do_reset();
        t.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        t.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        t.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        t.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        t.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        t.push_back(mk(1, 1, 0, 1, 1, 1, 0));
        t.push_back(mk(1, 1, 0, 1, 1, 0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            o = obs_f3();
            vecs++;
            if (o !== e) begin
                errs++;
                $display("FAIL filter[%0d] got y=%0d cf=%b adv=%b tout=%b want y=%0d cf=%b adv=%b tout=%b",
                         i, o.y, o.cf, o.adv, o.tout, e.y, e.cf, e.adv, e.tout);
            end
        end
    endtask

    task automatic test_reverse();
        row_t t[$];
        exp_t e, o;
        do_reset();
        t.push_back(mk(0, 1, 1, 0, 0, 0, 0));
        t.push_back(mk(1, 1, 1, 4, 1, 1, 0));
        t.push_back(mk(1, 1, 1, 4, 1, 0, 0));
        t.push_back(mk(0, 1, 1, 3, 0, 1, 0));
        t.push_back(mk(0, 1, 1, 3, 0, 0, 0));
        t.push_back(mk(1, 1, 0, 4, 1, 1, 0));
        t.push_back(mk(0, 1, 0, 0, 0, 1, 0));
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            o = obs_r5();
            vecs++;
            if (o !== e) begin
                errs++;
                $display("FAIL reverse[%0d] got y=%0d cf=%b adv=%b tout=%b want y=%0d cf=%b adv=%b tout=%b",
                         i, o.y, o.cf, o.adv, o.tout, e.y, e.cf, e.adv, e.tout);
            end
        end
    endtask

    task automatic test_timeout();
        row_t t[$];
        exp_t e, o;
        do_reset();
        t.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        t.push_back(mk(1, 1, 0, 1, 1, 1, 0));
        for (int k = 1; k <= 7; k++) t.push_back(mk(1, 1, 0, 1, 1, 0, 0));
        t.push_back(mk(1, 1, 0, 0, 1, 0, 1));
        t.push_back(mk(1, 1, 0, 0, 1, 0, 0));
        // Second pass: a commit lands on the expiry edge and must win.
        t.push_back(mk(0, 1, 0, 1, 0, 1, 0));
        for (int k = 1; k <= 7; k++) t.push_back(mk(0, 1, 0, 1, 0, 0, 0));
        t.push_back(mk(1, 1, 0, 2, 1, 1, 0));
        t.push_back(mk(1, 1, 0, 2, 1, 0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            o = obs_to();
            vecs++;
            if (o !== e) begin
                errs++;
                $display("FAIL timeout[%0d] got y=%0d cf=%b adv=%b tout=%b want y=%0d cf=%b adv=%b tout=%b",
                         i, o.y, o.cf, o.adv, o.tout, e.y, e.cf, e.adv, e.tout);
            end
        end
    endtask

    task automatic test_enable();
        row_t t[$];
        exp_t e, o;
        do_reset();
        t.push_back(mk(1, 1, 0, 1, 1, 1, 0));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 0));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 0));
        t.push_back(mk(1, 0, 0, 1, 1, 0, 0));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 0));
        t.push_back(mk(0, 1, 0, 1, 0, 0, 0));
        t.push_back(mk(0, 1, 0, 1, 0, 0, 0));
        t.push_back(mk(1, 1, 0, 2, 1, 1, 0));
        t.push_back(mk(1, 1, 0, 2, 1, 0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            o = obs_def();
            vecs++;
            if (o !== e) begin
                errs++;
                $display("FAIL enable[%0d] got y=%0d cf=%b adv=%b tout=%b want y=%0d cf=%b adv=%b tout=%b",
                         i, o.y, o.cf, o.adv, o.tout, e.y, e.cf, e.adv, e.tout);
            end
        end
    endtask

    task automatic test_async_reset();
        row_t t[$];
        exp_t e, o;
        do_reset();
        t.push_back(mk(1, 1, 0, 1, 1, 1, 0));
        t.push_back(mk(0, 1, 0, 2, 0, 1, 0));
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            o = obs_def();
            vecs++;
            if (o !== e) begin
                errs++;
                $display("FAIL async_pre[%0d] got y=%0d cf=%b adv=%b tout=%b want y=%0d cf=%b adv=%b tout=%b",
                         i, o.y, o.cf, o.adv, o.tout, e.y, e.cf, e.adv, e.tout);
            end
        end
        // Mid-cycle reset must clear outputs before any clock edge.
        #2;
        reset = 1'b1;
        sb.push_back('0);
        #1;
        e = sb.pop_front();
        o = obs_def();
        vecs++;
        if (o !== e) begin
            errs++;
            $display("FAIL async_mid got y=%0d cf=%b adv=%b tout=%b want all zero",
                     o.y, o.cf, o.adv, o.tout);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        t.delete();
        t.push_back(mk(1, 1, 0, 1, 1, 1, 0));
        t.push_back(mk(1, 1, 0, 1, 1, 0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            o = obs_def();
            vecs++;
            if (o !== e) begin
                errs++;
                $display("FAIL async_post[%0d] got y=%0d cf=%b adv=%b tout=%b want y=%0d cf=%b adv=%b tout=%b",
                         i, o.y, o.cf, o.adv, o.tout, e.y, e.cf, e.adv, e.tout);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_steps();
        test_filter();
        test_reverse();
        test_timeout();
        test_enable();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
